// File: rtl/meter_count_adder_if.sv
// Button, load-switch and decrement inputs plus the count/flag outputs of the
// meter count adder, bundled so the producer and consumer share one port.
interface meter_count_adder_if;
   logic [3:0]  btn;
   logic [1:0]  sw_load;
   logic        dec;
   logic [13:0] BCOUNT;
   logic        zero;
   logic        add_ack;

   modport master (
      output btn, sw_load, dec,
      input  BCOUNT, zero, add_ack
   );

   modport slave (
      input  btn, sw_load, dec,
      output BCOUNT, zero, add_ack
   );
endinterface

// File: rtl/meter_count_adder.sv
// Saturating 0..9999 s time counter: synchronized, edge-detected add/load
// events with fixed priority, plus a per-cycle decrement strobe.
module meter_count_adder #(
   parameter int MAX_COUNT = 9999,
   parameter int ADD0      = 50,
   parameter int ADD1      = 150,
   parameter int ADD2      = 200,
   parameter int ADD3      = 500,
   parameter int LOAD0     = 10,
   parameter int LOAD1     = 205
) (
   input  logic              clk,
   input  logic              reset,
   meter_count_adder_if.slave bus
);

   localparam logic signed [14:0] MAX_S  = 15'(MAX_COUNT);
   localparam logic signed [14:0] ADD0_S = 15'(ADD0);
   localparam logic signed [14:0] ADD1_S = 15'(ADD1);
   localparam logic signed [14:0] ADD2_S = 15'(ADD2);
   localparam logic signed [14:0] ADD3_S = 15'(ADD3);

   // Bit order doubles as priority order: highest index wins.
   logic [5:0]         raw;
   logic [5:0]         sync_p0;
   logic [5:0]         sync_p1;
   logic [5:0]         prev_p2;
   logic [5:0]         rise;
   logic [13:0]        count_p2;
   logic [13:0]        count_nxt;
   logic               zero_p2;
   logic               add_ack_p2;
   logic               event_any;
   logic signed [14:0] cnt_s;
   logic signed [14:0] dec_s;

   function automatic logic [13:0] sat_count(input logic signed [14:0] v);
      if (v < 15'sd0)
         return 14'd0;
      if (v > MAX_S)
         return 14'(MAX_COUNT);
      return v[13:0];
   endfunction

   assign raw   = {bus.sw_load, bus.btn};
   assign rise  = sync_p1 & ~prev_p2;
   assign cnt_s = $signed({1'b0, count_p2});
   assign dec_s = $signed({14'd0, bus.dec});

   // Stage 2: single winning event, or the bare decrement, forms the next count.
   always_comb begin
      count_nxt = count_p2;
      event_any = 1'b1;
      if (rise[5])
         count_nxt = 14'(LOAD1);
      else if (rise[4])
         count_nxt = 14'(LOAD0);
      else if (rise[3])
         count_nxt = sat_count(cnt_s + ADD3_S - dec_s);
      else if (rise[2])
         count_nxt = sat_count(cnt_s + ADD2_S - dec_s);
      else if (rise[1])
         count_nxt = sat_count(cnt_s + ADD1_S - dec_s);
      else if (rise[0])
         count_nxt = sat_count(cnt_s + ADD0_S - dec_s);
      else begin
         event_any = 1'b0;
         count_nxt = sat_count(cnt_s - dec_s);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_p0    <= '0;
         sync_p1    <= '0;
         prev_p2    <= '0;
         count_p2   <= '0;
         zero_p2    <= 1'b1;
         add_ack_p2 <= 1'b0;
      end else begin
         // Stage 0/1: two-flop synchronizer; stage 2 keeps the previous sample.
         sync_p0    <= raw;
         sync_p1    <= sync_p0;
         prev_p2    <= sync_p1;
         count_p2   <= count_nxt;
         zero_p2    <= (count_nxt == 14'd0);
         add_ack_p2 <= event_any;
      end
   end

   assign bus.BCOUNT  = count_p2;
   assign bus.zero    = zero_p2;
   assign bus.add_ack = add_ack_p2;

endmodule
